// File: rtl/velocity_cell_reader.sv
// velocity_cell_reader: reads a cell's particle count from cache address 0, then streams velocities 1..N through a 4-entry credit-limited FIFO.
module velocity_cell_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [ADDR_WIDTH-1:0]     out_read_address,
  output logic                      out_rden,
  input  logic [3*DATA_WIDTH-1:0]   in_particle_info,
  output logic [3*DATA_WIDTH-1:0]   out_velocity,
  output logic [ADDR_WIDTH-1:0]     out_particle_id,
  output logic                      out_valid,
  input  logic                      in_ready,
  output logic [ADDR_WIDTH-1:0]     out_particle_count,
  output logic                      busy,
  output logic                      done,
  output logic                      count_error
);
  localparam int DW = 3 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_READ_COUNT = 3'd1;
  localparam logic [2:0] S_WAIT_COUNT = 3'd2;
  localparam logic [2:0] S_STREAM     = 3'd3;
  localparam logic [2:0] S_DRAIN      = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]               r_state;
  logic [ADDR_WIDTH-1:0]    r_addr, r_next, r_n, r_pa1, r_pa2;
  logic                     r_rden, r_p1, r_p2, r_c1, r_c2, r_err;
  logic [ADDR_WIDTH+DW-1:0] r_fifo [4];
  logic [1:0]               r_wp, r_rp;
  logic [2:0]               r_cnt;

  logic                     w_push, w_pop, w_issue, w_last;
  logic [3:0]               w_outstanding;
  logic [ADDR_WIDTH-1:0]    w_raw, w_n;
  logic [ADDR_WIDTH+DW-1:0] w_head;

  always_comb begin
    w_push        = r_p2;
    out_valid     = r_cnt != 3'd0;
    w_pop         = out_valid && in_ready;
    // every read in the address register or either return stage already owns a FIFO slot
    w_outstanding = 4'(r_rden) + 4'(r_p1) + 4'(r_p2) + {1'b0, r_cnt} - 4'(w_pop);
    w_issue       = (r_state == S_STREAM) && (w_outstanding < 4'd4);
    w_raw         = in_particle_info[ADDR_WIDTH-1:0];
    w_n           = (w_raw > MAX_N) ? MAX_N : w_raw;
    w_head        = r_fifo[r_rp];
    w_last        = w_pop && (w_head[ADDR_WIDTH+DW-1:DW] == r_n);
  end

  assign out_velocity       = out_valid ? w_head[DW-1:0] : '0;
  assign out_particle_id    = out_valid ? w_head[ADDR_WIDTH+DW-1:DW] : '0;
  assign out_read_address   = r_addr;
  assign out_rden           = r_rden;
  assign out_particle_count = r_n;
  assign count_error        = r_err;
  assign busy               = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done               = r_state == S_DONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_next  <= '0;
      r_n     <= '0;
      r_pa1   <= '0;
      r_pa2   <= '0;
      r_rden  <= 1'b0;
      r_p1    <= 1'b0;
      r_p2    <= 1'b0;
      r_c1    <= 1'b0;
      r_c2    <= 1'b0;
      r_err   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_rden <= w_issue || (r_state == S_IDLE && start);
      r_addr <= w_issue ? r_next : '0;
      // address 0 is the count read; it never enters the FIFO
      r_p1   <= r_rden && (|r_addr);
      r_c1   <= r_rden && !(|r_addr);
      r_p2   <= r_p1;
      r_c2   <= r_c1;
      r_pa1  <= r_addr;
      r_pa2  <= r_pa1;
      if (w_push) begin
        r_fifo[r_wp] <= {r_pa2, in_particle_info};
        r_wp         <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_READ_COUNT;
          r_err   <= 1'b0;
          r_next  <= ADDR_WIDTH'(1);
        end
        S_READ_COUNT: r_state <= S_WAIT_COUNT;
        S_WAIT_COUNT: if (r_c2) begin
          r_n     <= w_n;
          r_err   <= w_raw > MAX_N;
          r_state <= (w_n == '0) ? S_DONE : S_STREAM;
        end
        S_STREAM: if (w_issue) begin
          r_next  <= r_next + ADDR_WIDTH'(1);
          r_state <= (r_next == r_n) ? S_DRAIN : S_STREAM;
        end
        S_DRAIN: r_state <= w_last ? S_DONE : S_DRAIN;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
